// File: rtl/kvs_pkg.sv
// Shared constants for the KVS lookup-port arbiter: default key/flag widths
// and the requester index encoding stored in the tag FIFO.
package kvs_pkg;

   localparam int KVS_KEY_SIZE  = 96;
   localparam int KVS_FLAG_SIZE = 4;

   localparam logic PORT_ETH0 = 1'b0;
   localparam logic PORT_ETH1 = 1'b1;

endpackage

// File: rtl/kvs_tag_fifo.sv
// In-order 1-bit tag FIFO recording which requester issued each outstanding
// lookup. Synchronous, head look-ahead, occupancy exported.
module kvs_tag_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push,
   input  logic        push_data,
   input  logic        pop,
   output logic        head,
   output logic        full,
   output logic        empty,
   output logic [AW:0] occ
);

   localparam logic [AW:0] OCC_FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic             push_eff, pop_eff;

   assign full  = (occ_q == OCC_FULL);
   assign empty = (occ_q == '0);
   assign occ   = occ_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      push_eff = push & ~full;
      pop_eff  = pop & ~empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push_eff) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop_eff) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_eff, pop_eff})
         2'b10:   occ_d = occ_q + 1'b1;
         2'b01:   occ_d = occ_q - 1'b1;
         default: occ_d = occ_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

endmodule

// File: rtl/kvs_port_arbiter.sv
// Shares the single db_top KVS lookup port between ETH0 and ETH1 with
// round-robin grants and in-order result steering. Optional counters: KVS_ARB_STATS_EN.
module kvs_port_arbiter
   import kvs_pkg::*;
#(
   parameter int KEY_SIZE  = KVS_KEY_SIZE,
   parameter int FLAG_SIZE = KVS_FLAG_SIZE,
   parameter int TAG_DEPTH = 16,
   parameter int TAG_AW    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [KEY_SIZE-1:0]  s0_key,
   input  logic [FLAG_SIZE-1:0] s0_flag,
   input  logic                 s0_valid,
   output logic                 s0_ready,
   output logic                 s0_resp_valid,
   output logic [FLAG_SIZE-1:0] s0_resp_flag,
   input  logic [KEY_SIZE-1:0]  s1_key,
   input  logic [FLAG_SIZE-1:0] s1_flag,
   input  logic                 s1_valid,
   output logic                 s1_ready,
   output logic                 s1_resp_valid,
   output logic [FLAG_SIZE-1:0] s1_resp_flag,
   output logic [KEY_SIZE-1:0]  m_key,
   output logic [FLAG_SIZE-1:0] m_flag,
   output logic                 m_valid,
   input  logic                 m_resp_valid,
   input  logic [FLAG_SIZE-1:0] m_resp_flag
`ifdef KVS_ARB_STATS_EN
   ,
   output logic [31:0]          grant_cnt0,
   output logic [31:0]          grant_cnt1,
   output logic [31:0]          orphan_cnt
`endif
);

   localparam logic [TAG_AW:0] OCC_FULL = (TAG_AW+1)'(TAG_DEPTH);

   // Handshake: a request moves when sX_valid & sX_ready; sX_ready is a pure
   // function of valids, last grant and FIFO occupancy (never of m_resp_valid).
   logic                 elig, gnt0, gnt1;
   logic                 last_q, last_d;
   logic                 m_valid_q, m_valid_d;
   logic [KEY_SIZE-1:0]  m_key_q, m_key_d;
   logic [FLAG_SIZE-1:0] m_flag_q, m_flag_d;
   logic                 r0_valid_q, r0_valid_d, r1_valid_q, r1_valid_d;
   logic [FLAG_SIZE-1:0] r0_flag_q, r0_flag_d, r1_flag_q, r1_flag_d;

   logic                 tag_push, tag_push_data, tag_pop, tag_head;
   logic                 tag_full, tag_empty;
   logic [TAG_AW:0]      tag_occ;

   kvs_tag_fifo #(
      .DEPTH (TAG_DEPTH),
      .AW    (TAG_AW)
   ) u_tag_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tag_push),
      .push_data (tag_push_data),
      .pop       (tag_pop),
      .head      (tag_head),
      .full      (tag_full),
      .empty     (tag_empty),
      .occ       (tag_occ)
   );

   always_comb begin
      elig = (tag_occ != OCC_FULL) && !rst;
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      // On a tie the requester that did not win last time is served.
      if (elig) begin
         if (s0_valid && (!s1_valid || last_q == PORT_ETH1)) gnt0 = 1'b1;
         else if (s1_valid)                                  gnt1 = 1'b1;
      end

      last_d = last_q;
      if (gnt0)      last_d = PORT_ETH0;
      else if (gnt1) last_d = PORT_ETH1;

      m_valid_d = gnt0 | gnt1;
      m_key_d   = m_key_q;
      m_flag_d  = m_flag_q;
      if (gnt0) begin
         m_key_d  = s0_key;
         m_flag_d = s0_flag;
      end else if (gnt1) begin
         m_key_d  = s1_key;
         m_flag_d = s1_flag;
      end

      tag_push      = (gnt0 | gnt1) & ~tag_full;
      tag_push_data = gnt1 ? PORT_ETH1 : PORT_ETH0;

      // A response with nothing outstanding is an orphan and is dropped.
      tag_pop    = m_resp_valid & ~tag_empty;
      r0_valid_d = tag_pop && (tag_head == PORT_ETH0);
      r1_valid_d = tag_pop && (tag_head == PORT_ETH1);
      r0_flag_d  = r0_valid_d ? m_resp_flag : r0_flag_q;
      r1_flag_d  = r1_valid_d ? m_resp_flag : r1_flag_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q     <= PORT_ETH1;
         m_valid_q  <= 1'b0;
         m_key_q    <= '0;
         m_flag_q   <= '0;
         r0_valid_q <= 1'b0;
         r1_valid_q <= 1'b0;
         r0_flag_q  <= '0;
         r1_flag_q  <= '0;
      end else begin
         last_q     <= last_d;
         m_valid_q  <= m_valid_d;
         m_key_q    <= m_key_d;
         m_flag_q   <= m_flag_d;
         r0_valid_q <= r0_valid_d;
         r1_valid_q <= r1_valid_d;
         r0_flag_q  <= r0_flag_d;
         r1_flag_q  <= r1_flag_d;
      end
   end

   assign s0_ready      = gnt0;
   assign s1_ready      = gnt1;
   assign m_valid       = m_valid_q;
   assign m_key         = m_key_q;
   assign m_flag        = m_flag_q;
   assign s0_resp_valid = r0_valid_q;
   assign s1_resp_valid = r1_valid_q;
   assign s0_resp_flag  = r0_flag_q;
   assign s1_resp_flag  = r1_flag_q;

`ifdef KVS_ARB_STATS_EN
   logic [31:0] grant_cnt0_q, grant_cnt0_d;
   logic [31:0] grant_cnt1_q, grant_cnt1_d;
   logic [31:0] orphan_cnt_q, orphan_cnt_d;

   always_comb begin
      grant_cnt0_d = grant_cnt0_q + {31'd0, gnt0};
      grant_cnt1_d = grant_cnt1_q + {31'd0, gnt1};
      orphan_cnt_d = orphan_cnt_q + {31'd0, m_resp_valid & tag_empty};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_cnt0_q <= '0;
         grant_cnt1_q <= '0;
         orphan_cnt_q <= '0;
      end else begin
         grant_cnt0_q <= grant_cnt0_d;
         grant_cnt1_q <= grant_cnt1_d;
         orphan_cnt_q <= orphan_cnt_d;
      end
   end

   assign grant_cnt0 = grant_cnt0_q;
   assign grant_cnt1 = grant_cnt1_q;
   assign orphan_cnt = orphan_cnt_q;
`endif

endmodule

// File: tb/tb_kvs_port_arbiter.sv
// Directed bench for kvs_port_arbiter: queue-based reference model checked every
// cycle, plus literal expectations for the listed scenarios. Optional: KVS_ARB_STATS_EN.
module tb_kvs_port_arbiter;

   localparam int KW = 96;
   localparam int FW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [KW-1:0] s0_key = '0, s1_key = '0;
   logic [FW-1:0] s0_flag = '0, s1_flag = '0;
   logic          s0_valid = 1'b0, s1_valid = 1'b0;
   logic          s0_ready, s1_ready;
   logic          s0_resp_valid, s1_resp_valid;
   logic [FW-1:0] s0_resp_flag, s1_resp_flag;
   logic [KW-1:0] m_key;
   logic [FW-1:0] m_flag;
   logic          m_valid;
   logic          m_resp_valid = 1'b0;
   logic [FW-1:0] m_resp_flag = '0;
`ifdef KVS_ARB_STATS_EN
   logic [31:0]   grant_cnt0, grant_cnt1, orphan_cnt;
`endif

   kvs_port_arbiter dut (
      .clk           (clk),
      .rst           (rst),
      .s0_key        (s0_key),
      .s0_flag       (s0_flag),
      .s0_valid      (s0_valid),
      .s0_ready      (s0_ready),
      .s0_resp_valid (s0_resp_valid),
      .s0_resp_flag  (s0_resp_flag),
      .s1_key        (s1_key),
      .s1_flag       (s1_flag),
      .s1_valid      (s1_valid),
      .s1_ready      (s1_ready),
      .s1_resp_valid (s1_resp_valid),
      .s1_resp_flag  (s1_resp_flag),
      .m_key         (m_key),
      .m_flag        (m_flag),
      .m_valid       (m_valid),
      .m_resp_valid  (m_resp_valid),
      .m_resp_flag   (m_resp_flag)
`ifdef KVS_ARB_STATS_EN
      ,
      .grant_cnt0    (grant_cnt0),
      .grant_cnt1    (grant_cnt1),
      .orphan_cnt    (orphan_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model state: what the DUT outputs should hold after the last edge.
   bit            tag_q[$];
   bit            mdl_last = 1'b1;
   logic          exp_m_valid = 1'b0;
   logic [KW-1:0] exp_m_key = '0;
   logic [FW-1:0] exp_m_flag = '0;
   logic          exp_r_valid [2] = '{1'b0, 1'b0};
   logic [FW-1:0] exp_r_flag [2] = '{4'h0, 4'h0};
   logic [31:0]   exp_gcnt [2] = '{32'd0, 32'd0};
   logic [31:0]   exp_ocnt = '0;

   // Observed behaviour logs, appended from DUT outputs.
   int            g_log[$];
   logic [FW-1:0] r0_log[$];
   logic [FW-1:0] r1_log[$];

   always @(negedge clk) begin
      bit e0, e1;
      bit p;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst && tag_q.size() < 16) begin
         if (s0_valid && (!s1_valid || mdl_last)) e0 = 1'b1;
         else if (s1_valid)                       e1 = 1'b1;
      end

      chk("s0_ready", KW'(s0_ready), KW'(e0));
      chk("s1_ready", KW'(s1_ready), KW'(e1));
      chk("m_valid", KW'(m_valid), KW'(exp_m_valid));
      chk("m_key", m_key, exp_m_key);
      chk("m_flag", KW'(m_flag), KW'(exp_m_flag));
      chk("s0_resp_valid", KW'(s0_resp_valid), KW'(exp_r_valid[0]));
      chk("s1_resp_valid", KW'(s1_resp_valid), KW'(exp_r_valid[1]));
      chk("s0_resp_flag", KW'(s0_resp_flag), KW'(exp_r_flag[0]));
      chk("s1_resp_flag", KW'(s1_resp_flag), KW'(exp_r_flag[1]));
`ifdef KVS_ARB_STATS_EN
      chk("grant_cnt0", KW'(grant_cnt0), KW'(exp_gcnt[0]));
      chk("grant_cnt1", KW'(grant_cnt1), KW'(exp_gcnt[1]));
      chk("orphan_cnt", KW'(orphan_cnt), KW'(exp_ocnt));
`endif

      if (s0_ready && s0_valid) g_log.push_back(0);
      if (s1_ready && s1_valid) g_log.push_back(1);
      if (s0_resp_valid) r0_log.push_back(s0_resp_flag);
      if (s1_resp_valid) r1_log.push_back(s1_resp_flag);

      // Advance the model to the state the coming clock edge must produce.
      if (rst) begin
         tag_q.delete();
         mdl_last    = 1'b1;
         exp_m_valid = 1'b0;
         exp_m_key   = '0;
         exp_m_flag  = '0;
         exp_r_valid = '{1'b0, 1'b0};
         exp_r_flag  = '{4'h0, 4'h0};
         exp_gcnt    = '{32'd0, 32'd0};
         exp_ocnt    = '0;
      end else begin
         exp_r_valid = '{1'b0, 1'b0};
         if (m_resp_valid) begin
            if (tag_q.size() == 0) begin
               exp_ocnt++;
            end else begin
               p = tag_q.pop_front();
               exp_r_valid[p] = 1'b1;
               exp_r_flag[p]  = m_resp_flag;
            end
         end
         exp_m_valid = e0 | e1;
         if (e0) begin
            exp_m_key  = s0_key;
            exp_m_flag = s0_flag;
            mdl_last   = 1'b0;
            exp_gcnt[0]++;
            tag_q.push_back(1'b0);
         end else if (e1) begin
            exp_m_key  = s1_key;
            exp_m_flag = s1_flag;
            mdl_last   = 1'b1;
            exp_gcnt[1]++;
            tag_q.push_back(1'b1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic respond(input logic [FW-1:0] f);
      m_resp_valid = 1'b1;
      m_resp_flag  = f;
      tick();
      m_resp_valid = 1'b0;
   endtask

   task automatic issue(input int port, input logic [KW-1:0] k, input logic [FW-1:0] f);
      if (port == 0) begin
         s0_valid = 1'b1; s0_key = k; s0_flag = f;
      end else begin
         s1_valid = 1'b1; s1_key = k; s1_flag = f;
      end
      tick();
      s0_valid = 1'b0;
      s1_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Single requester round trip.
      s0_valid = 1'b1;
      s0_key   = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A501;
      s0_flag  = 4'h1;
      #1;
      chk("t1_ready_same_cycle", KW'(s0_ready), KW'(1));
      tick();
      s0_valid = 1'b0;
      chk("t1_m_valid", KW'(m_valid), KW'(1));
      chk("t1_m_key", m_key, 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A501);
      chk("t1_m_flag", KW'(m_flag), KW'(4'h1));
      respond(4'h3);
      chk("t1_s0_resp_valid", KW'(s0_resp_valid), KW'(1));
      chk("t1_s0_resp_flag", KW'(s0_resp_flag), KW'(4'h3));
      chk("t1_s1_resp_valid", KW'(s1_resp_valid), KW'(0));
      tick();

      // Contention for 8 cycles after reset.
      do_reset();
      g_log.delete();
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s0_key = KW'(32'h1000 + i);
         s1_key = KW'(32'h2000 + i);
         tick();
      end
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      chk("t2_grant_count", KW'(g_log.size()), KW'(8));
      for (int i = 0; i < 8; i++) chk("t2_grant_order", KW'(g_log[i]), KW'(i % 2));
`ifdef KVS_ARB_STATS_EN
      chk("t2_grant_cnt0", KW'(grant_cnt0), KW'(4));
      chk("t2_grant_cnt1", KW'(grant_cnt1), KW'(4));
`endif
      for (int i = 0; i < 8; i++) respond(FW'(i));
      tick();

      // Fill the tag FIFO from requester 0 only.
      do_reset();
      g_log.delete();
      s0_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         s0_key = KW'(32'h3000 + i);
         tick();
      end
      chk("t3_grants_to_full", KW'(g_log.size()), KW'(16));
      chk("t3_ready_when_full", KW'(s0_ready), KW'(0));
      respond(4'h9);
      for (int i = 0; i < 4; i++) tick();
      chk("t3_grants_after_pop", KW'(g_log.size()), KW'(17));
      s0_valid = 1'b0;
      tick();

      // In-order routing 0,1,1,0.
      do_reset();
      r0_log.delete();
      r1_log.delete();
      issue(0, 96'h40, 4'h0);
      issue(1, 96'h41, 4'h1);
      issue(1, 96'h42, 4'h2);
      issue(0, 96'h43, 4'h3);
      respond(4'h4);
      respond(4'h5);
      respond(4'h6);
      respond(4'h7);
      tick();
      tick();
      chk("t4_s0_count", KW'(r0_log.size()), KW'(2));
      chk("t4_s1_count", KW'(r1_log.size()), KW'(2));
      chk("t4_s0_first", KW'(r0_log[0]), KW'(4'h4));
      chk("t4_s0_second", KW'(r0_log[1]), KW'(4'h7));
      chk("t4_s1_first", KW'(r1_log[0]), KW'(4'h5));
      chk("t4_s1_second", KW'(r1_log[1]), KW'(4'h6));

      // Orphans and reset with lookups outstanding.
      do_reset();
      r0_log.delete();
      r1_log.delete();
      respond(4'hE);
      tick();
      chk("t5_orphan_no_resp", KW'(r0_log.size() + r1_log.size()), KW'(0));
`ifdef KVS_ARB_STATS_EN
      chk("t5_orphan_cnt", KW'(orphan_cnt), KW'(1));
`endif
      issue(0, 96'h50, 4'h0);
      issue(1, 96'h51, 4'h1);
      issue(0, 96'h52, 4'h2);
      do_reset();
      respond(4'hA);
      respond(4'hB);
      respond(4'hC);
      tick();
      chk("t5_post_reset_orphans", KW'(r0_log.size() + r1_log.size()), KW'(0));
`ifdef KVS_ARB_STATS_EN
      chk("t5_orphan_cnt_after_reset", KW'(orphan_cnt), KW'(3));
`endif
      g_log.delete();
      s0_valid = 1'b1;
      s1_valid = 1'b1;
      tick();
      s0_valid = 1'b0;
      s1_valid = 1'b0;
      chk("t5_tie_after_reset_count", KW'(g_log.size()), KW'(1));
      chk("t5_tie_after_reset_port", KW'(g_log[0]), KW'(0));
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
